// File: rtl/prng_arbiter_ctrl_if.sv
// prng_arbiter_ctrl_if: request/grant and response channel between requesters and the PRNG arbiter
//   master: requester side, drives req and rsp_ready
//   slave : arbiter side, drives grant and the rsp_* response fields
interface prng_arbiter_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int SEED_W = 9,
  parameter int DATA_W = 512
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic rsp_valid;
  logic rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic rsp_err;
  logic [SEED_W-1:0] rsp_seed;
  modport master (output req, rsp_ready, input grant, rsp_valid, rsp_data, rsp_id, rsp_err, rsp_seed);
  modport slave (input req, rsp_ready, output grant, rsp_valid, rsp_data, rsp_id, rsp_err, rsp_seed);
endinterface

// File: rtl/prng_arbiter_ctrl.sv
// prng_arbiter_ctrl: round-robin sharing of one LFSR PRNG between requesters, with seed sequencing and timeout
//   clk, rst_n          : clock, synchronous active-low reset
//   bus (slave)         : req/grant and valid/ready response channel (data, id, err, seed)
//   seed_base(_we)      : reload of the seed counter, taken only while idle
//   busy, err_sticky    : transaction in progress, any timeout since reset
//   prng_*              : generator control (reset, seed load, seed) and result (out, done)
module prng_arbiter_ctrl #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int SEED_W = 9,
  parameter int DATA_W = 512,
  parameter int TIMEOUT = 600
) (
  input  logic clk,
  input  logic rst_n,
  prng_arbiter_ctrl_if.slave bus,
  input  logic [SEED_W-1:0] seed_base,
  input  logic seed_base_we,
  output logic busy,
  output logic err_sticky,
  output logic prng_rst,
  output logic prng_load_seed,
  output logic [SEED_W-1:0] prng_seed,
  input  logic [DATA_W-1:0] prng_out,
  input  logic prng_done
);
  localparam int CNT_W = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, GEN, RESP} state_t;
  state_t state, next;
  logic [ID_W-1:0] ptr, win, idx;
  logic hit;
  logic [SEED_W-1:0] seed_reg, seed_inc;
  logic [CNT_W-1:0] cnt;
  logic expired;
  // Scan downward so the nearest set bit after ptr is the last assignment and wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
  // Seed sequence skips 0, which would lock the LFSR.
  assign seed_inc = (seed_reg == '1) ? SEED_W'(1) : seed_reg + 1'b1;
  assign expired = cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    next = state;
    case (state)
      IDLE: next = hit ? CLR : IDLE;
      CLR: next = LOAD;
      LOAD: next = GEN;
      GEN: next = (prng_done || expired) ? RESP : GEN;
      RESP: next = bus.rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.rsp_data <= '0;
      bus.rsp_id <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_seed <= '0;
      err_sticky <= 1'b0;
      ptr <= ID_W'(N_REQ - 1);
      seed_reg <= SEED_W'(1);
      cnt <= '0;
    end else begin
      state <= next;
      case (state)
        IDLE:
          if (hit) begin
            bus.grant <= N_REQ'(1) << win;
            bus.rsp_id <= win;
            ptr <= win;
            bus.rsp_seed <= seed_reg;
          end else if (seed_base_we) begin
            seed_reg <= (seed_base == '0) ? SEED_W'(1) : seed_base;
          end
        LOAD: seed_reg <= seed_inc;
        GEN:
          if (prng_done) begin
            bus.rsp_data <= prng_out;
            bus.rsp_err <= 1'b0;
            cnt <= '0;
          end else if (expired) begin
            bus.rsp_data <= '0;
            bus.rsp_err <= 1'b1;
            err_sticky <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        RESP:
          if (bus.rsp_ready) bus.grant <= '0;
        default: ;
      endcase
    end
  end
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign prng_rst = !rst_n || state == CLR;
  assign prng_load_seed = state == LOAD;
  assign prng_seed = bus.rsp_seed;
endmodule
